// File: rtl/seg7_scroll_ctrl.sv
// seg7_scroll_ctrl: scrolls a 4-digit window across a message buffer and
// drives the display register bank (one-hot segment select, value, Write).
// Every output is a register. Next-cycle values are computed from the next
// state, so the first Write appears the cycle after start is sampled.
// Optional build macro: SEG7_SCROLL_BOUNCE_EN. When it is defined, the window
// bounces back and forth instead of wrapping around.
module seg7_scroll_ctrl #(
    parameter int TICK_DIV  = 25000000,
    parameter int MSG_DEPTH = 16,
    parameter int AW        = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          msg_wr,
    input  logic [AW-1:0] msg_addr,
    input  logic [8:0]    msg_data,
    input  logic [AW:0]   msg_len,
    input  logic          start,
    input  logic          stop,
    output logic [3:0]    segment,
    output logic [8:0]    seg_value,
    output logic          Write,
    output logic          busy,
    output logic [AW-1:0] pos
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REF0 = 3'd1,
        S_REF1 = 3'd2,
        S_REF2 = 3'd3,
        S_REF3 = 3'd4,
        S_WAIT = 3'd5
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(MSG_DEPTH);

    logic [8:0]    r_mem [MSG_DEPTH];
    state_t        r_state, w_state_nx;
    logic [AW-1:0] r_pos, w_pos_nx, w_pos_adv;
    logic [AW-1:0] r_idx, w_idx_nx, w_idx_inc;
    logic [AW:0]   r_len, w_len_nx;
    logic [31:0]   r_cnt, w_cnt_nx;
    logic          r_stop_pend, w_stop_nx;
    logic [3:0]    r_segment, w_seg_nx;
    logic [8:0]    r_seg_value, w_val_nx;
    logic          r_write, w_write_nx;
    logic          r_busy;
    logic          w_start_go, w_step;

    assign w_start_go = (r_state == S_IDLE) && start && !stop;
    assign w_step     = (r_state == S_WAIT) && !stop && (r_cnt == 32'(TICK_DIV - 1));

    // The read index walks through the message, with one conditional wrap per digit
    assign w_idx_inc = (({1'b0, r_idx} + (AW+1)'(1)) == r_len) ? '0 : r_idx + AW'(1);

`ifdef SEG7_SCROLL_BOUNCE_EN
    logic r_dir;      // 0 = forward, 1 = reverse
    logic w_dir_adv;

    // Bounce advance: go forward up to len-4, then back down to 0
    always_comb begin
        w_dir_adv = r_dir;
        w_pos_adv = r_pos;
        if (r_len <= (AW+1)'(4)) begin
            w_dir_adv = 1'b0;
            w_pos_adv = '0;
        end else if (!r_dir) begin
            if (({1'b0, r_pos} + (AW+1)'(4)) == r_len) begin
                w_dir_adv = 1'b1;
                w_pos_adv = r_pos - AW'(1);
            end else begin
                w_pos_adv = r_pos + AW'(1);
            end
        end else begin
            if (r_pos == '0) begin
                w_dir_adv = 1'b0;
                w_pos_adv = r_pos + AW'(1);
            end else begin
                w_pos_adv = r_pos - AW'(1);
            end
        end
    end

    // Direction register: start sets it to forward, and each scroll step updates it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dir <= 1'b0;
        end else if (w_start_go) begin
            r_dir <= 1'b0;
        end else if (w_step) begin
            r_dir <= w_dir_adv;
        end
    end
`else
    // Wrap-around advance
    always_comb begin
        w_pos_adv = (({1'b0, r_pos} + (AW+1)'(1)) == r_len) ? '0 : r_pos + AW'(1);
    end
`endif

    // Message buffer write port (the buffer is not reset)
    always_ff @(posedge clock) begin
        if (msg_wr) begin
            r_mem[msg_addr] <= msg_data;
        end
    end

    // Next-state logic for the sequencer, the window position and the tick counter
    always_comb begin
        w_state_nx = r_state;
        w_pos_nx   = r_pos;
        w_idx_nx   = r_idx;
        w_len_nx   = r_len;
        w_cnt_nx   = r_cnt;
        w_stop_nx  = r_stop_pend;
        case (r_state)
            S_IDLE: begin
                w_stop_nx = 1'b0;
                if (w_start_go) begin
                    w_state_nx = S_REF0;
                    w_len_nx   = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
                    w_pos_nx   = '0;
                    w_idx_nx   = '0;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_REF0: begin
                w_state_nx = S_REF1;
                w_idx_nx   = w_idx_inc;
                w_stop_nx  = r_stop_pend | stop;
            end
            S_REF1: begin
                w_state_nx = S_REF2;
                w_idx_nx   = w_idx_inc;
                w_stop_nx  = r_stop_pend | stop;
            end
            S_REF2: begin
                w_state_nx = S_REF3;
                w_idx_nx   = w_idx_inc;
                w_stop_nx  = r_stop_pend | stop;
            end
            S_REF3: begin
                w_cnt_nx  = '0;
                w_stop_nx = 1'b0;
                if (r_stop_pend || stop || (r_len == '0)) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    w_state_nx = S_IDLE;
                end else if (w_step) begin
                    w_state_nx = S_REF0;
                    w_pos_nx   = w_pos_adv;
                    w_idx_nx   = w_pos_adv;
                end else begin
                    w_cnt_nx = r_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state and read index
    always_comb begin
        w_write_nx = 1'b0;
        w_seg_nx   = 4'b0000;
        w_val_nx   = 9'h000;
        case (w_state_nx)
            S_REF0: begin
                w_write_nx = 1'b1;
                w_seg_nx   = 4'b0001;
            end
            S_REF1: begin
                w_write_nx = 1'b1;
                w_seg_nx   = 4'b0010;
            end
            S_REF2: begin
                w_write_nx = 1'b1;
                w_seg_nx   = 4'b0100;
            end
            S_REF3: begin
                w_write_nx = 1'b1;
                w_seg_nx   = 4'b1000;
            end
            default: begin
                w_write_nx = 1'b0;
                w_seg_nx   = 4'b0000;
            end
        endcase
        if (w_write_nx && (w_len_nx != '0)) begin
            w_val_nx = r_mem[w_idx_nx];
        end else begin
            w_val_nx = 9'h000;
        end
    end

    // State, control and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pos       <= '0;
            r_idx       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_stop_pend <= 1'b0;
            r_segment   <= 4'b0000;
            r_seg_value <= 9'h000;
            r_write     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pos       <= w_pos_nx;
            r_idx       <= w_idx_nx;
            r_len       <= w_len_nx;
            r_cnt       <= w_cnt_nx;
            r_stop_pend <= w_stop_nx;
            r_segment   <= w_seg_nx;
            r_seg_value <= w_val_nx;
            r_write     <= w_write_nx;
            r_busy      <= (w_state_nx != S_IDLE);
        end
    end

    assign segment   = r_segment;
    assign seg_value = r_seg_value;
    assign Write     = r_write;
    assign busy      = r_busy;
    assign pos       = r_pos;

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// Self-checking bench for seg7_scroll_ctrl. Expected values come from a
// message-level model: the bench keeps a shadow copy of the buffer and works
// out each pass's window position with plain arithmetic.
module tb_seg7_scroll_ctrl;
    localparam int TICK_DIV  = 4;
    localparam int MSG_DEPTH = 16;
    localparam int AW        = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          msg_wr = 1'b0;
    logic [AW-1:0] msg_addr = '0;
    logic [8:0]    msg_data = '0;
    logic [AW:0]   msg_len = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [3:0]    segment;
    logic [8:0]    seg_value;
    logic          Write;
    logic          busy;
    logic [AW-1:0] pos;

    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] mdl_mem [MSG_DEPTH];

    seg7_scroll_ctrl #(.TICK_DIV(TICK_DIV), .MSG_DEPTH(MSG_DEPTH), .AW(AW)) dut (
        .clock(clock), .reset(reset), .msg_wr(msg_wr), .msg_addr(msg_addr),
        .msg_data(msg_data), .msg_len(msg_len), .start(start), .stop(stop),
        .segment(segment), .seg_value(seg_value), .Write(Write), .busy(busy), .pos(pos)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Window start position for pass n of a message of length L
    function automatic int exp_pos(input int n, input int L);
`ifdef SEG7_SCROLL_BOUNCE_EN
        int per;
        int r;
        if (L <= 4) return 0;
        per = 2 * (L - 4);
        r = n % per;
        return (r <= L - 4) ? r : per - r;
`else
        if (L == 0) return 0;
        return n % L;
`endif
    endfunction

    task automatic write_mem(input int a, input logic [8:0] d);
        msg_wr = 1'b1;
        msg_addr = AW'(a);
        msg_data = d;
        tick();
        msg_wr = 1'b0;
        mdl_mem[AW'(a)] = d;
    endtask

    task automatic do_start(input int len);
        msg_len = (AW+1)'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Check the four refresh cycles; inj=1 pulses stop at REF1, inj=2 pulses start there
    task automatic check_pass(input int n, input int L, input int inj);
        int p;
        p = exp_pos(n, L);
        for (int k = 0; k < 4; k++) begin
            logic [8:0] ev;
            ev = (L == 0) ? 9'h000 : mdl_mem[AW'((p + k) % L)];
            chk("ref_write", 32'(Write), 32'd1);
            chk("ref_segment", 32'(segment), 32'(1 << k));
            chk("ref_value", 32'(seg_value), 32'(ev));
            chk("ref_pos", 32'(pos), 32'(p));
            chk("ref_busy", 32'(busy), 32'd1);
            if (k == 1 && inj == 1) stop = 1'b1;
            if (k == 1 && inj == 2) begin
                start = 1'b1;
                msg_len = 5'd3;
            end
            tick();
            stop = 1'b0;
            start = 1'b0;
        end
    endtask

    task automatic check_wait(input bit do_wr);
        for (int i = 0; i < TICK_DIV; i++) begin
            chk("wait_write", 32'(Write), 32'd0);
            chk("wait_segment", 32'(segment), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
            if (i == 0 && do_wr) begin
                write_mem($urandom_range(0, MSG_DEPTH - 1), 9'($urandom));
            end else begin
                tick();
            end
        end
    endtask

    task automatic check_idle(input int p, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            chk("idle_write", 32'(Write), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_pos", 32'(pos), 32'(p));
            tick();
        end
    endtask

    task automatic stop_in_wait(input int p);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_idle(p, 3);
    endtask

    initial begin
        int L;
        int raw;
        #1 reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("rst_segment", 32'(segment), 32'd0);
        chk("rst_value", 32'(seg_value), 32'd0);
        chk("rst_write", 32'(Write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pos", 32'(pos), 32'd0);
        reset = 1'b0;
        tick();

        // Six-entry message, seven passes, then stop in WAIT
        for (int a = 0; a < 6; a++) write_mem(a, 9'(9'h11 + a));
        do_start(6);
        for (int n = 0; n < 7; n++) begin
            check_pass(n, 6, 0);
            if (n < 6) check_wait(1'b0);
        end
        stop_in_wait(exp_pos(6, 6));

        // Two-entry message wraps inside the window; stop at REF1 finishes the pass
        write_mem(0, 9'h00A);
        write_mem(1, 9'h00B);
        do_start(2);
        check_pass(0, 2, 0);
        check_wait(1'b0);
        check_pass(1, 2, 1);
        check_idle(exp_pos(1, 2), 4);

        // Zero length: four blank writes, then idle
        do_start(0);
        check_pass(0, 0, 0);
        check_idle(0, 3);

        // start and stop together in IDLE: stop wins
        msg_len = 5'd6;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        check_idle(0, 4);

        // start while busy (with a msg_len change) is ignored
        for (int a = 0; a < 8; a++) write_mem(a, 9'($urandom));
        do_start(8);
        check_pass(0, 8, 2);
        check_wait(1'b0);
        check_pass(1, 8, 0);
        check_wait(1'b0);
        check_pass(2, 8, 0);
        stop_in_wait(exp_pos(2, 8));

        // Random messages and lengths (including over-length), writes while busy
        for (int it = 0; it < 5; it++) begin
            for (int a = 0; a < MSG_DEPTH; a++) write_mem(a, 9'($urandom));
            raw = (it == 0) ? 20 : $urandom_range(1, 20);
            L = (raw > MSG_DEPTH) ? MSG_DEPTH : raw;
            do_start(raw);
            for (int n = 0; n < 4; n++) begin
                check_pass(n, L, 0);
                if (n < 3) check_wait(1'b1);
            end
            stop_in_wait(exp_pos(3, L));
        end

        // Asynchronous reset during REF2
        do_start(6);
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_write", 32'(Write), 32'd0);
        chk("arst_segment", 32'(segment), 32'd0);
        chk("arst_value", 32'(seg_value), 32'd0);
        chk("arst_pos", 32'(pos), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        check_idle(0, 8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
